// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the round-robin grant controller.
//   state_t   : arbiter FSM state (IDLE, OWNED)
//   HOLD_W    : width of the hold-time counter (timeout build only)
//   id_width  : index width for an N-entry requester vector
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Wide enough for any practical HOLD_MAX; the counter saturates anyway.
  localparam int HOLD_W = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority search: finds the first set bit of req,
// starting at position ptr and wrapping from N-1 back to 0.
// Ports:
//   req   in  N     candidate request vector
//   ptr   in  IDW   search start position (must be < N)
//   found out 1     at least one bit of req is set
//   idx   out IDW   index of the winning bit (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int k;

  // Scan offsets from farthest to nearest so the nearest hit to ptr is the
  // last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// rr_grant_ctrl
// Round-robin, lock-until-release grant controller for one shared resource.
// A requester keeps the grant for as long as its request stays high; on
// release the search restarts just after the previous holder, and a pending
// requester is granted at that same edge with no idle cycle in between.
//
// Optional feature: define RR_TIMEOUT_EN to revoke a grant held for HOLD_MAX
// cycles when another requester is waiting.
//
// Ports:
//   clock     in   1       rising-edge clock
//   reset_n   in   1       asynchronous active-low reset
//   req       in   N_REQ   request vector, bit i = requester i
//   gnt       out  N_REQ   registered one-hot grant (zero when idle)
//   gnt_valid out  1       registered, equals |gnt
//   gnt_id    out  IDW     registered index of the holder (0 when idle)
// -----------------------------------------------------------------------------
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_REQ-1:0]              req,
  output logic [N_REQ-1:0]              gnt,
  output logic                          gnt_valid,
  output logic [id_width(N_REQ)-1:0]    gnt_id
);

  localparam int IDW = id_width(N_REQ);

  state_t           state, state_d;
  logic [IDW-1:0]   rr_ptr, ptr_d;
  logic [N_REQ-1:0] gnt_d;
  logic [IDW-1:0]   id_d;
  logic [IDW-1:0]   inc_id;
  logic [IDW-1:0]   pick_ptr;
  logic [N_REQ-1:0] pick_req;
  logic             found;
  logic [IDW-1:0]   pick_idx;
  logic             rel_now;
  logic             revoke;
  logic             new_grant;

  assign inc_id = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);

  // While owned, the next candidate search always begins after the holder,
  // and the holder itself is excluded so a revoke cannot re-select it.
  assign pick_ptr = (state == IDLE) ? rr_ptr : inc_id;
  assign pick_req = req & ~gnt;

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign rel_now = (state == OWNED) && !req[gnt_id];

`ifdef RR_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_cnt;

  assign revoke = (state == OWNED) && req[gnt_id] && (hold_cnt == HOLD_LAST) && found;

  // Counts cycles spent owned; restarts on every new grant and saturates
  // when the holder is alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (new_grant) begin
      hold_cnt <= '0;
    end else if ((state == OWNED) && (hold_cnt != HOLD_LAST)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
`else
  // HOLD_MAX and the new-grant strobe only matter to the timeout counter.
  logic unused_hold;
  assign revoke      = 1'b0;
  assign unused_hold = new_grant ^ (HOLD_MAX > 0);
`endif

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    id_d      = gnt_id;
    ptr_d     = rr_ptr;
    new_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d         = OWNED;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          id_d            = pick_idx;
          new_grant       = 1'b1;
        end
      end
      OWNED: begin
        if (rel_now || revoke) begin
          ptr_d = inc_id;
          if (found) begin
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            id_d            = pick_idx;
            new_grant       = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  // ---- state and output registers ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= ptr_d;
      gnt       <= gnt_d;
      gnt_valid <= |gnt_d;
      gnt_id    <= id_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_ctrl
// Directed bench for rr_grant_ctrl (N_REQ=4, HOLD_MAX=16). The lock case runs
// in the default build; the timeout case runs when RR_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_rr_grant_ctrl;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;

  int checks = 0;
  int passed = 0;

  rr_grant_ctrl #(
    .N_REQ    (4),
    .HOLD_MAX (16)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input logic [3:0] g, input logic [1:0] id);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_id"}, 32'(gnt_id), 32'(id));
    check({tag, "_valid"}, 32'(gnt_valid), 32'(|g));
  endtask

  initial begin
    // 1. reset with all requesting
    reset_n = 1'b0;
    req     = 4'b1111;
    tick(2);
    expect_gnt("reset", 4'b0000, 2'd0);
    reset_n = 1'b1;
    tick(1);
    expect_gnt("post_reset", 4'b0001, 2'd0);
    req = 4'b0000;
    tick(1);
    expect_gnt("drop0", 4'b0000, 2'd0);

    // 2. single requester (rr_ptr is now 1)
    req = 4'b0100;
    tick(1);
    expect_gnt("single", 4'b0100, 2'd2);
    req = 4'b0000;
    tick(1);
    expect_gnt("single_drop", 4'b0000, 2'd0);

    // rr_ptr is 3: search wraps past 3 to 0
    req = 4'b0011;
    tick(1);
    expect_gnt("wrap", 4'b0001, 2'd0);
    req = 4'b0010;
    tick(1);
    expect_gnt("handoff", 4'b0010, 2'd1);
    req = 4'b0000;
    tick(1);
    expect_gnt("idle_again", 4'b0000, 2'd0);

    // 3. rotation from rr_ptr=0
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    req = 4'b1111;
    tick(1);
    expect_gnt("rot0", 4'b0001, 2'd0);
    tick(1);
    expect_gnt("rot0_hold", 4'b0001, 2'd0);
    req = 4'b1110;
    tick(1);
    expect_gnt("rot1", 4'b0010, 2'd1);
    req = 4'b1111;
    tick(1);
    expect_gnt("rot1_hold", 4'b0010, 2'd1);
    req = 4'b1101;
    tick(1);
    expect_gnt("rot2", 4'b0100, 2'd2);
    req = 4'b1111;
    tick(1);
    req = 4'b1011;
    tick(1);
    expect_gnt("rot3", 4'b1000, 2'd3);
    req = 4'b1111;
    tick(1);
    req = 4'b0111;
    tick(1);
    expect_gnt("rot_wrap0", 4'b0001, 2'd0);

`ifdef RR_TIMEOUT_EN
    // 5. timeout: grant on 0 with 3 waiting, revoked after 16 owned cycles
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    req = 4'b1001;
    tick(1);
    expect_gnt("to_grant", 4'b0001, 2'd0);
    tick(15);
    expect_gnt("to_before", 4'b0001, 2'd0);
    tick(1);
    expect_gnt("to_revoke", 4'b1000, 2'd3);
    req = 4'b1000;
    tick(1);
    expect_gnt("pre_async", 4'b1000, 2'd3);
`else
    // 4. lock: requester 1 holds indefinitely while 0 waits
    req = 4'b0010;
    tick(1);
    expect_gnt("lock_start", 4'b0010, 2'd1);
    req = 4'b0011;
    tick(40);
    expect_gnt("lock_held", 4'b0010, 2'd1);
    req = 4'b1000;
    tick(1);
    expect_gnt("pre_async", 4'b1000, 2'd3);
`endif

    // 6. async reset between edges while gnt=1000, rr_ptr nonzero
    #2;
    reset_n = 1'b0;
    #1;
    expect_gnt("async_drop", 4'b0000, 2'd0);
    #1;
    reset_n = 1'b1;
    req = 4'b1111;
    tick(1);
    expect_gnt("async_rearb", 4'b0001, 2'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
